sy_l2_cache_victim_ctrl: RTL

//  Replacement-side client of the L2 tree-PLRU array. Drives the PLRU array's lookup and update ports:
//  - hits update the PLRU;
//  - misses read the PLRU, choose a victim way (invalid way first), hand it to the refill path, then mark it MRU.

---
 rtl/sy_l2_cache_victim_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sy_l2_cache_victim_ctrl.sv
// L2 replacement controller: forwards hit updates to the tree-PLRU array and, on a miss,
// looks up the PLRU, picks a victim way (invalid way first), hands it to refill, then marks it MRU.
module sy_l2_cache_victim_ctrl #(
  parameter  int unsigned SET_WTH = 6,
  parameter  int unsigned WAY_NUM = 4,
  localparam int unsigned WAY_WTH = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_vld_i,
  output logic               req_rdy_o,
  input  logic [SET_WTH-1:0] req_set_i,
  input  logic               req_hit_i,
  input  logic [WAY_WTH-1:0] req_hit_way_i,
  input  logic [WAY_NUM-1:0] req_way_vld_i,
  input  logic [WAY_NUM-1:0] req_way_dirty_i,
  output logic [SET_WTH-1:0] lookup_lru_set_o,
  input  logic [WAY_WTH-1:0] lookup_lru_way_i,
  output logic               update_lru_o,
  output logic [SET_WTH-1:0] update_lru_set_o,
  output logic [WAY_WTH-1:0] update_lru_way_o,
  output logic               vict_vld_o,
  input  logic               vict_rdy_i,
  output logic [SET_WTH-1:0] vict_set_o,
  output logic [WAY_WTH-1:0] vict_way_o,
  output logic               vict_dirty_o,
  output logic               vict_from_lru_o,
  input  logic               refill_done_i,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, LOOKUP, SEL, VICT, REFILL} state_t;

  state_t               state_q, state_d;
  logic [SET_WTH-1:0]   set_q, set_d;
  logic [WAY_NUM-1:0]   vld_q, vld_d;
  logic [WAY_NUM-1:0]   dirty_q, dirty_d;

  logic                 req_rdy_d;
  logic [SET_WTH-1:0]   lookup_set_d;
  logic                 upd_d;
  logic [SET_WTH-1:0]   upd_set_d;
  logic [WAY_WTH-1:0]   upd_way_d;
  logic                 vict_vld_d;
  logic [SET_WTH-1:0]   vict_set_d;
  logic [WAY_WTH-1:0]   vict_way_d;
  logic                 vict_dirty_d;
  logic                 vict_from_lru_d;
  logic [31:0]          hit_cnt_d;
  logic [31:0]          miss_cnt_d;

  logic                 accept;
  logic                 any_inv;
  logic [WAY_WTH-1:0]   lowest_inv;
  logic [WAY_WTH-1:0]   victim;
  logic                 victim_dirty;

  assign accept = req_vld_i & req_rdy_o;

  // Victim choice: lowest-index invalid way beats the PLRU suggestion.
  always_comb begin
    any_inv    = 1'b0;
    lowest_inv = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        any_inv    = 1'b1;
        lowest_inv = WAY_WTH'(i);
      end
    end
    if (WAY_NUM == 1) begin
      victim = '0;
    end else begin
      victim = any_inv ? lowest_inv : lookup_lru_way_i;
    end
    victim_dirty = vld_q[victim] & dirty_q[victim];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    set_d           = set_q;
    vld_d           = vld_q;
    dirty_d         = dirty_q;
    upd_d           = 1'b0;
    upd_set_d       = '0;
    upd_way_d       = '0;
    vict_vld_d      = vict_vld_o;
    vict_set_d      = vict_set_o;
    vict_way_d      = vict_way_o;
    vict_dirty_d    = vict_dirty_o;
    vict_from_lru_d = vict_from_lru_o;
    hit_cnt_d       = hit_cnt_o;
    miss_cnt_d      = miss_cnt_o;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_hit_i) begin
            upd_d     = 1'b1;
            upd_set_d = req_set_i;
            upd_way_d = req_hit_way_i;
            hit_cnt_d = (hit_cnt_o == CNT_MAX) ? CNT_MAX : hit_cnt_o + 32'd1;
          end else begin
            set_d      = req_set_i;
            vld_d      = req_way_vld_i;
            dirty_d    = req_way_dirty_i;
            miss_cnt_d = (miss_cnt_o == CNT_MAX) ? CNT_MAX : miss_cnt_o + 32'd1;
            state_d    = LOOKUP;
          end
        end
      end
      LOOKUP: state_d = SEL;
      SEL: begin
        vict_vld_d      = 1'b1;
        vict_set_d      = set_q;
        vict_way_d      = victim;
        vict_dirty_d    = victim_dirty;
        vict_from_lru_d = !any_inv;
        state_d         = VICT;
      end
      VICT: begin
        if (vict_rdy_i) begin
          vict_vld_d = 1'b0;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (refill_done_i) begin
          upd_d     = 1'b1;
          upd_set_d = set_q;
          upd_way_d = vict_way_o;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_rdy_d    = (state_d == IDLE);
    lookup_set_d = (state_d == IDLE) ? '0 : set_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      set_q            <= '0;
      vld_q            <= '0;
      dirty_q          <= '0;
      req_rdy_o        <= 1'b1;
      lookup_lru_set_o <= '0;
      update_lru_o     <= 1'b0;
      update_lru_set_o <= '0;
      update_lru_way_o <= '0;
      vict_vld_o       <= 1'b0;
      vict_set_o       <= '0;
      vict_way_o       <= '0;
      vict_dirty_o     <= 1'b0;
      vict_from_lru_o  <= 1'b0;
      hit_cnt_o        <= '0;
      miss_cnt_o       <= '0;
    end else begin
      state_q          <= state_d;
      set_q            <= set_d;
      vld_q            <= vld_d;
      dirty_q          <= dirty_d;
      req_rdy_o        <= req_rdy_d;
      lookup_lru_set_o <= lookup_set_d;
      update_lru_o     <= upd_d;
      update_lru_set_o <= upd_set_d;
      update_lru_way_o <= upd_way_d;
      vict_vld_o       <= vict_vld_d;
      vict_set_o       <= vict_set_d;
      vict_way_o       <= vict_way_d;
      vict_dirty_o     <= vict_dirty_d;
      vict_from_lru_o  <= vict_from_lru_d;
      hit_cnt_o        <= hit_cnt_d;
      miss_cnt_o       <= miss_cnt_d;
    end
  end

endmodule
